// File: rtl/gain_pkg.sv
// Shared constants and helpers for the gain blocks: coefficient format,
// channel-index sizing, register map and output saturation.
package gain_pkg;

  localparam int unsigned ADDR_COEF_BASE = 0;

  typedef struct packed {
    logic        sat;
    logic [63:0] val;
  } sat_t;

  function automatic int unsigned ch_width(input int unsigned ch_num);
    return (ch_num > 1) ? $clog2(ch_num) : 1;
  endfunction

  // Unity gain in sfi(w, w/2)
  function automatic logic [31:0] coef_one(input int unsigned coef_wdt);
    return 32'd1 << (coef_wdt / 2);
  endfunction

  // The flag register sits directly above the last coefficient
  function automatic int unsigned flag_addr(input int unsigned ch_num);
    return ADDR_COEF_BASE + ch_num;
  endfunction

  function automatic sat_t saturate(input logic signed [63:0] x, input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_t               r;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = ~hi;
    if (x > hi) begin
      r.sat = 1'b1;
      r.val = hi;
    end else if (x < lo) begin
      r.sat = 1'b1;
      r.val = lo;
    end else begin
      r.sat = 1'b0;
      r.val = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/gain_mul_sat.sv
// Two-stage multiply / round-half-up / saturate pipeline with a per-sample
// saturation indication aligned to the output register update.
module gain_mul_sat
  import gain_pkg::*;
#(
  parameter int unsigned A_WDT    = 16,
  parameter int unsigned COEF_WDT = 16,
  parameter int unsigned CH_W     = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic [CH_W-1:0]     i_channel,
  input  logic [A_WDT-1:0]    i_data,
  input  logic [COEF_WDT-1:0] i_coef,
  output logic                o_valid,
  output logic [CH_W-1:0]     o_channel,
  output logic [A_WDT-1:0]    o_data,
  output logic                o_sat_set,
  output logic [CH_W-1:0]     o_sat_ch
);

  localparam int unsigned P_W  = A_WDT + COEF_WDT;
  localparam int unsigned FRAC = COEF_WDT / 2;
  localparam logic signed [P_W:0] RND = (P_W + 1)'(32'd1 << (FRAC - 1));

  logic signed [P_W-1:0] w_a_ext;
  logic signed [P_W-1:0] w_c_ext;
  logic signed [P_W-1:0] r_prod;
  logic                  r_valid;
  logic [CH_W-1:0]       r_ch;
  logic signed [P_W:0]   w_rnd;
  logic signed [63:0]    w_shift;
  sat_t                  w_sat;
  logic                  w_unused_hi;

  assign w_a_ext = P_W'($signed(i_data));
  assign w_c_ext = P_W'($signed(i_coef));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_prod  <= '0;
      r_ch    <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_prod <= w_a_ext * w_c_ext;
        r_ch   <= i_channel;
      end
    end
  end

  // One guard bit keeps the rounding add from wrapping at the product extreme
  assign w_rnd       = $signed({r_prod[P_W-1], r_prod}) + RND;
  assign w_shift     = 64'(w_rnd >>> FRAC);
  assign w_sat       = saturate(w_shift, A_WDT);
  assign w_unused_hi = ^w_sat.val[63:A_WDT];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid   <= 1'b0;
      o_channel <= '0;
      o_data    <= '0;
    end else begin
      o_valid <= r_valid;
      if (r_valid) begin
        o_channel <= r_ch;
        o_data    <= w_sat.val[A_WDT-1:0];
      end
    end
  end

  assign o_sat_set = r_valid & w_sat.sat;
  assign o_sat_ch  = r_ch;

endmodule

// File: rtl/gain_mc_ramp.sv
// Multi-channel gain: per-channel coefficients over Avalon-MM, sticky
// saturation flags, 3-cycle sample pipeline. GAIN_RAMP_EN adds coefficient ramping.
module gain_mc_ramp
  import gain_pkg::*;
#(
  parameter int unsigned A_WDT     = 16,
  parameter int unsigned COEF_WDT  = 16,
  parameter int unsigned CH_NUM    = 4,
  parameter int unsigned RAMP_STEP = 16,
  localparam int unsigned CH_W     = ch_width(CH_NUM)
) (
  input  logic                csi_clk,
  input  logic                rsi_reset,
  input  logic [CH_W:0]       avs_address,
  input  logic                avs_write,
  input  logic                avs_read,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata,
  input  logic                asi_valid,
  input  logic [CH_W-1:0]     asi_channel,
  input  logic [A_WDT-1:0]    asi_data,
  output logic                aso_valid,
  output logic [CH_W-1:0]     aso_channel,
  output logic [A_WDT-1:0]    aso_data
);

  localparam int unsigned AW = CH_W + 1;
  localparam logic [AW-1:0] CH_LIM    = AW'(CH_NUM);
  localparam logic [AW-1:0] FLAG_ADDR = AW'(flag_addr(CH_NUM));
  localparam logic [COEF_WDT-1:0] ONE = COEF_WDT'(coef_one(COEF_WDT));

  logic [COEF_WDT-1:0] r_tgt [CH_NUM];
  logic [CH_NUM-1:0]   r_flags;
  logic [CH_NUM-1:0]   w_flags_d;
  logic [31:0]         r_rdata;
  logic [31:0]         w_rdata;
  logic                w_acc;
  logic                w_coef_wr;
  logic                w_flag_wr;
  logic [CH_W-1:0]     w_reg_ch;
  logic [COEF_WDT-1:0] w_coef_use;
  logic                r_s1_valid;
  logic [CH_W-1:0]     r_s1_ch;
  logic [A_WDT-1:0]    r_s1_data;
  logic [COEF_WDT-1:0] r_s1_coef;
  logic                w_sat_set;
  logic [CH_W-1:0]     w_sat_ch;
  logic                w_unused;

  assign w_unused  = ^{avs_writedata, 32'(RAMP_STEP)};
  assign w_acc     = asi_valid && ({1'b0, asi_channel} < CH_LIM);
  assign w_coef_wr = avs_write && (avs_address < CH_LIM);
  assign w_flag_wr = avs_write && (avs_address == FLAG_ADDR);
  assign w_reg_ch  = CH_W'(avs_address - AW'(ADDR_COEF_BASE));

  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      for (int i = 0; i < CH_NUM; i++) r_tgt[i] <= ONE;
    end else if (w_coef_wr) begin
      r_tgt[w_reg_ch] <= avs_writedata[COEF_WDT-1:0];
    end
  end

`ifdef GAIN_RAMP_EN
  localparam int unsigned RW = COEF_WDT + 33;
  localparam logic signed [RW-1:0] STEP_S = RW'(RAMP_STEP);

  logic [COEF_WDT-1:0] r_cur [CH_NUM];
  logic signed [RW-1:0] w_cur_s;
  logic signed [RW-1:0] w_tgt_s;
  logic signed [RW-1:0] w_up;
  logic signed [RW-1:0] w_dn;
  logic [COEF_WDT-1:0]  w_cur_nxt;

  always_comb begin
    w_cur_s   = RW'($signed(r_cur[asi_channel]));
    w_tgt_s   = RW'($signed(r_tgt[asi_channel]));
    w_up      = w_cur_s + STEP_S;
    w_dn      = w_cur_s - STEP_S;
    w_cur_nxt = r_tgt[asi_channel];
    if (w_tgt_s > w_cur_s) begin
      if (w_up < w_tgt_s) w_cur_nxt = w_up[COEF_WDT-1:0];
    end else if (w_tgt_s < w_cur_s) begin
      if (w_dn > w_tgt_s) w_cur_nxt = w_dn[COEF_WDT-1:0];
    end
  end

  // Only the channel whose sample is accepted advances toward its target
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      for (int i = 0; i < CH_NUM; i++) r_cur[i] <= ONE;
    end else if (w_acc) begin
      r_cur[asi_channel] <= w_cur_nxt;
    end
  end

  assign w_coef_use = r_cur[asi_channel];
`else
  assign w_coef_use = r_tgt[asi_channel];
`endif

  // S1: coefficient sampled before this edge's write lands
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      r_s1_valid <= 1'b0;
      r_s1_ch    <= '0;
      r_s1_data  <= '0;
      r_s1_coef  <= '0;
    end else begin
      r_s1_valid <= w_acc;
      if (w_acc) begin
        r_s1_ch   <= asi_channel;
        r_s1_data <= asi_data;
        r_s1_coef <= w_coef_use;
      end
    end
  end

  gain_mul_sat #(
    .A_WDT    (A_WDT),
    .COEF_WDT (COEF_WDT),
    .CH_W     (CH_W)
  ) u_mul_sat (
    .i_clk     (csi_clk),
    .i_rst     (rsi_reset),
    .i_valid   (r_s1_valid),
    .i_channel (r_s1_ch),
    .i_data    (r_s1_data),
    .i_coef    (r_s1_coef),
    .o_valid   (aso_valid),
    .o_channel (aso_channel),
    .o_data    (aso_data),
    .o_sat_set (w_sat_set),
    .o_sat_ch  (w_sat_ch)
  );

  // Set is applied after clear so a coincident saturation survives
  always_comb begin
    w_flags_d = r_flags;
    if (w_flag_wr) w_flags_d = '0;
    if (w_sat_set) w_flags_d[w_sat_ch] = 1'b1;
  end

  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) r_flags <= '0;
    else           r_flags <= w_flags_d;
  end

  always_comb begin
    w_rdata = '0;
    if (avs_address < CH_LIM) begin
      w_rdata = 32'(r_tgt[w_reg_ch]);
    end else if (avs_address == FLAG_ADDR) begin
      for (int c = 0; c < CH_NUM && c < 32; c++) w_rdata[c] = r_flags[c];
    end
  end

  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset)     r_rdata <= '0;
    else if (avs_read) r_rdata <= w_rdata;
  end

  assign avs_readdata = r_rdata;

endmodule

// File: tb/tb_gain_mc_ramp.sv
// Scoreboard bench for gain_mc_ramp: directed samples and register accesses,
// expected outputs queued at issue and checked by an independent monitor.
`timescale 1ns/1ps
module tb_gain_mc_ramp;

  logic        csi_clk = 1'b0;
  logic        rsi_reset = 1'b1;
  logic [2:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        asi_valid = 1'b0;
  logic [1:0]  asi_channel = '0;
  logic [15:0] asi_data = '0;
  logic        aso_valid;
  logic [1:0]  aso_channel;
  logic [15:0] aso_data;

  int          total = 0;
  int          bad = 0;
  logic [15:0] q_data[$];
  logic [1:0]  q_ch[$];
  logic [15:0] exp_d;
  logic [1:0]  exp_c;

  always #5 csi_clk = ~csi_clk;

  gain_mc_ramp #(
    .A_WDT     (16),
    .COEF_WDT  (16),
    .CH_NUM    (4),
    .RAMP_STEP (64)
  ) dut (
    .csi_clk       (csi_clk),
    .rsi_reset     (rsi_reset),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_read      (avs_read),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .asi_valid     (asi_valid),
    .asi_channel   (asi_channel),
    .asi_data      (asi_data),
    .aso_valid     (aso_valid),
    .aso_channel   (aso_channel),
    .aso_data      (aso_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented output must match the oldest queued expectation
  always @(negedge csi_clk) begin
    if (!rsi_reset && aso_valid) begin
      if (q_data.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got ch%0d 0x%0h want no output", aso_channel, aso_data);
      end else begin
        exp_d = q_data.pop_front();
        exp_c = q_ch.pop_front();
        check("out_data", 32'(aso_data), 32'(exp_d));
        check("out_ch", 32'(aso_channel), 32'(exp_c));
      end
    end
  end

  task automatic tick();
    @(posedge csi_clk);
    #1;
  endtask

  task automatic send(input logic [1:0] ch, input logic [15:0] d, input logic [15:0] e);
    asi_valid   = 1'b1;
    asi_channel = ch;
    asi_data    = d;
    q_data.push_back(e);
    q_ch.push_back(ch);
    tick();
    asi_valid = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_write     = 1'b1;
    avs_address   = a;
    avs_writedata = d;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string name);
    avs_read    = 1'b1;
    avs_address = a;
    tick();
    avs_read = 1'b0;
    check(name, avs_readdata, e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q_data.size() != 0; i++) tick();
    tick();
    if (q_data.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", q_data.size());
      q_data.delete();
      q_ch.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int seen;
    repeat (3) @(posedge csi_clk);
    #1;
    check("rst_aso_valid", 32'(aso_valid), 32'h0);
    check("rst_aso_data", 32'(aso_data), 32'h0);
    check("rst_aso_ch", 32'(aso_channel), 32'h0);
    check("rst_readdata", avs_readdata, 32'h0);
    rsi_reset = 1'b0;
    tick();

    for (int a = 0; a < 4; a++) rd(3'(a), 32'h0100, "reset_coef");
    rd(3'd4, 32'h0, "reset_flags");
    send(2'd0, 16'h4000, 16'h4000);
    drain();

    wr(3'd5, 32'h1234);
    rd(3'd5, 32'h0, "unmapped_rd");
    rd(3'd0, 32'h0100, "unmapped_wr_ignored");

`ifdef GAIN_RAMP_EN
    wr(3'd0, 32'h0200);
    send(2'd0, 16'h1000, 16'h1000);
    send(2'd0, 16'h1000, 16'h1400);
    send(2'd0, 16'h1000, 16'h1800);
    send(2'd0, 16'h1000, 16'h1C00);
    send(2'd0, 16'h1000, 16'h2000);
    drain();
    rd(3'd0, 32'h0200, "ramp_target");
`else
    wr(3'd1, 32'h0080);
    rd(3'd1, 32'h0080, "coef1_rb");
    send(2'd1, 16'h4000, 16'h2000);
    send(2'd1, 16'h0001, 16'h0001);
    send(2'd1, 16'hFFFF, 16'h0000);
    drain();
    rd(3'd4, 32'h0, "flags_nosat");

    wr(3'd2, 32'h0200);
    send(2'd2, 16'h4000, 16'h7FFF);
    send(2'd2, 16'hC000, 16'h8000);
    drain();
    rd(3'd4, 32'h4, "flag2_set");
    wr(3'd4, 32'h0);
    rd(3'd4, 32'h0, "flags_clr");

    send(2'd2, 16'h4000, 16'h7FFF);
    tick();
    wr(3'd4, 32'h0);
    drain();
    rd(3'd4, 32'h4, "set_beats_clear");
    wr(3'd4, 32'h0);

    wr(3'd0, 32'h0180);
    wr(3'd3, 32'hFF00);
    send(2'd0, 16'h1000, 16'h1800);
    send(2'd1, 16'h1000, 16'h0800);
    send(2'd2, 16'h1000, 16'h2000);
    send(2'd3, 16'h1000, 16'hF000);
    drain();

    avs_write     = 1'b1;
    avs_address   = 3'd0;
    avs_writedata = 32'h0040;
    asi_valid     = 1'b1;
    asi_channel   = 2'd0;
    asi_data      = 16'h1000;
    q_data.push_back(16'h1800);
    q_ch.push_back(2'd0);
    tick();
    avs_write = 1'b0;
    asi_valid = 1'b0;
    send(2'd0, 16'h1000, 16'h0400);
    drain();
    rd(3'd0, 32'h0040, "coef0_new");
`endif

    // Three samples in flight, then reset lands mid-cycle
    asi_valid   = 1'b1;
    asi_channel = 2'd1;
    asi_data    = 16'h1000;
    tick();
    asi_channel = 2'd2;
    tick();
    asi_channel = 2'd3;
    tick();
    asi_valid = 1'b0;
    rsi_reset = 1'b1;
    #1;
    check("rst_async_drop", 32'(aso_valid), 32'h0);
    tick();
    tick();
    rsi_reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge csi_clk);
      if (aso_valid) seen++;
    end
    check("no_out_after_rst", 32'(seen), 32'h0);
    check("rst_data_cleared", 32'(aso_data), 32'h0);
    tick();
    for (int a = 0; a < 4; a++) rd(3'(a), 32'h0100, "post_rst_coef");
    rd(3'd4, 32'h0, "post_rst_flags");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
